// File: rtl/muldiv_controller.sv
// Iterative RV32M/RV64M multiply/divide unit with valid/ready handshakes on both sides.
// Shift-add multiply and restoring divide, one bit per cycle; sign fix-up on DONE entry.
module muldiv_controller #(
    parameter int XLEN   = 32,
    parameter bit DIV_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            kill,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      instType,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_err,
    output logic            busy
);

    localparam logic [3:0]      INST_R_TYPE = 4'b0001;
    localparam int              CW          = $clog2(XLEN + 1);
    localparam logic [XLEN-1:0] MIN_NEG     = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [2:0]        op;
    logic              neg_q;
    logic              neg_r;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   dvsr;
    logic [XLEN:0]     rem;

    function automatic logic [XLEN-1:0] negate_x(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*XLEN-1:0] negate_2x(input logic [2*XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    logic            legal;
    logic            div_op;
    logic            sgn_div;
    logic            a_neg;
    logic            b_neg;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    always_comb begin
        div_op   = func3[2];
        legal    = (instType == INST_R_TYPE) && (func7 == 7'b0000001) && (!div_op || DIV_EN);
        sgn_div  = div_op && !func3[0];
        // MULH signs both operands, MULHSU only rs1; MUL/MULHU are unsigned
        a_neg    = ($signed(rs1_val) < 0) && (div_op ? sgn_div : (func3 == 3'b001 || func3 == 3'b010));
        b_neg    = ($signed(rs2_val) < 0) && (div_op ? sgn_div : (func3 == 3'b001));
        div_zero = (rs2_val == '0);
        div_ovf  = sgn_div && (rs1_val == MIN_NEG) && (rs2_val == '1);
        mag_a    = negate_x(rs1_val, a_neg);
        mag_b    = negate_x(rs2_val, b_neg);
    end

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] acc_step;
    logic [XLEN+1:0]   div_shift;
    logic [XLEN+1:0]   div_diff;
    logic [XLEN:0]     rem_step;
    logic [XLEN-1:0]   quo_step;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   calc_res;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_step  = {mul_sum, acc[XLEN-1:1]};
        div_shift = {rem, quo[XLEN-1]};
        div_diff  = div_shift - {2'b00, dvsr};
        rem_step  = div_diff[XLEN+1] ? div_shift[XLEN:0] : div_diff[XLEN:0];
        quo_step  = {quo[XLEN-2:0], ~div_diff[XLEN+1]};
        prod_fin  = negate_2x(acc_step, neg_q);
        if (op[2])
            calc_res = op[1] ? negate_x(rem_step[XLEN-1:0], neg_r) : negate_x(quo_step, neg_q);
        else
            calc_res = (op[1:0] == 2'b00) ? prod_fin[XLEN-1:0] : prod_fin[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            quo       <= '0;
            dvsr      <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            result    <= '0;
            out_err   <= 1'b0;
        end else if (kill) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op      <= func3;
                        out_err <= 1'b0;
                        if (!legal) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= '0;
                            out_err   <= 1'b1;
                        end else if (div_op && div_zero) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= func3[1] ? rs1_val : '1;
                        end else if (div_ovf) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= func3[1] ? '0 : rs1_val;
                        end else begin
                            state <= CALC;
                            cnt   <= CW'(XLEN);
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            mcand <= mag_b;
                            acc   <= {{XLEN{1'b0}}, mag_a};
                            rem   <= '0;
                            quo   <= mag_a;
                            dvsr  <= mag_b;
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt - 1'b1;
                    if (op[2]) begin
                        rem <= rem_step;
                        quo <= quo_step;
                    end else begin
                        acc <= acc_step;
                    end
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= calc_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_muldiv_controller.sv
// Scoreboard bench for muldiv_controller (XLEN=32): directed vectors, handshake, kill and reset cases.
module tb_muldiv_controller;

    localparam int         XLEN   = 32;
    localparam logic [3:0] INST_R = 4'b0001;
    localparam logic [6:0] F7M    = 7'b0000001;

    logic            clk;
    logic            rst_n;
    logic            kill;
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      instType;
    logic [2:0]      func3;
    logic [6:0]      func7;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            out_err;
    logic            busy;

    muldiv_controller #(.XLEN(XLEN), .DIV_EN(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .kill     (kill),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instType (instType),
        .func3    (func3),
        .func7    (func7),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .out_err  (out_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && !kill && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_err"}, out_err, mon_e.err);
            end
        end
    end

    task automatic send(input string name, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [3:0] it, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eres, input logic eerr, input int elat,
                        input bit push, input bit wait_hs);
        exp_t e;
        int   lat;
        @(negedge clk);
        instType = it;
        func3    = f3;
        func7    = f7;
        rs1_val  = a;
        rs2_val  = b;
        in_valid = 1'b1;
        if (push) begin
            e.res  = eres;
            e.err  = eerr;
            e.name = name;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rs1_val  = 32'h1234_5678;
        rs2_val  = 32'h0BAD_F00D;
        func3    = ~f3;
        if (elat > 0) begin
            lat = 1;
            while (!out_valid && lat < 100) begin
                @(posedge clk);
                #1;
                lat++;
            end
            chk({name, "_latency"}, lat, elat);
            if (wait_hs && out_ready) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen;
        rst_n     = 1'b0;
        kill      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        instType  = INST_R;
        func3     = 3'b000;
        func7     = F7M;
        rs1_val   = '0;
        rs2_val   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send("mul",        3'b000, F7M, INST_R, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 33, 1, 1);
        send("mulh",       3'b001, F7M, INST_R, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 33, 1, 1);
        send("mulhu",      3'b011, F7M, INST_R, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 33, 1, 1);
        send("mulhsu",     3'b010, F7M, INST_R, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 33, 1, 1);
        send("mulh_neg",   3'b001, F7M, INST_R, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 0, 33, 1, 1);
        send("div",        3'b100, F7M, INST_R, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 0, 33, 1, 1);
        send("rem",        3'b110, F7M, INST_R, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 0, 33, 1, 1);
        send("div_negb",   3'b100, F7M, INST_R, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 33, 1, 1);
        send("rem_negb",   3'b110, F7M, INST_R, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 0, 33, 1, 1);
        send("divu",       3'b101, F7M, INST_R, 32'd100,       32'd7,         32'd14,        0, 33, 1, 1);
        send("remu",       3'b111, F7M, INST_R, 32'd100,       32'd7,         32'd2,         0, 33, 1, 1);
        send("div_zero",   3'b100, F7M, INST_R, 32'd5,         32'd0,         32'hFFFF_FFFF, 0, 1, 1, 1);
        send("remu_zero",  3'b111, F7M, INST_R, 32'd5,         32'd0,         32'd5,         0, 1, 1, 1);
        send("div_ovf",    3'b100, F7M, INST_R, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 1, 1, 1);
        send("rem_ovf",    3'b110, F7M, INST_R, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 1, 1, 1);
        send("bad_func7",  3'b000, 7'b0000000, INST_R, 32'd3,  32'd4,         32'd0,         1, 1, 1, 1);
        send("bad_type",   3'b000, F7M, 4'b0010, 32'd3,        32'd4,         32'd0,         1, 1, 1, 1);
        send("mul_clr_err",3'b000, F7M, INST_R, 32'd9,         32'd9,         32'd81,        0, 33, 1, 1);

        // Consumer stalls in DONE for five cycles.
        out_ready = 1'b0;
        send("hold_mulhu", 3'b011, F7M, INST_R, 32'hFFFF_FFFF, 32'd2, 32'd1, 0, 33, 1, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold_out_valid", out_valid, 1);
            chk("hold_result", result, 1);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hs_in_ready", in_ready, 1);
        chk("hs_out_valid", out_valid, 0);
        chk("hs_result_kept", result, 1);
        send("b2b_divu",   3'b101, F7M, INST_R, 32'd1000,      32'd10,        32'd100,       0, 33, 1, 1);

        // Abort mid-calculation.
        send("kill_mul",   3'b000, F7M, INST_R, 32'd3,         32'd4,         32'd0,         0, 0, 0, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        chk("kill_in_ready", in_ready, 1);
        chk("kill_out_valid", out_valid, 0);
        chk("kill_busy", busy, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("kill_no_output", seen, 0);
        send("after_kill_mul", 3'b000, F7M, INST_R, 32'd3, 32'd4, 32'd12, 0, 33, 1, 1);

        // Reset mid-calculation.
        send("rst_divu",   3'b101, F7M, INST_R, 32'd77,        32'd5,         32'd0,         0, 0, 0, 0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_out_err", out_err, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send("post_rst_mul", 3'b000, F7M, INST_R, 32'd6, 32'd7, 32'd42, 0, 33, 1, 1);

        repeat (3) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_controller.md
Name: muldiv_controller

Overview:
- Parametrised successor to the single-cycle ALU op decoder. Adds the RV32M/RV64M multiply/divide path.
- Decodes R-type M-extension instructions (func7 = 7'b0000001) from instType/func3/func7 and executes them in an iterative engine, one bit per cycle.
- Sits beside the base ALU in the execute stage. Uses a valid/ready handshake on both sides so the pipeline can stall on busy.

Parameters:
- XLEN, 32, operand and result width; legal values 32 and 64.
- DIV_EN, 1, 1 = divide/remainder ops implemented; 0 = func3[2]=1 ops are reported as errors.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- kill  input  1  synchronous abort of the in-flight op.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- instType  input  4  instruction class; ops are legal only when instType equals the shared INST_R_TYPE constant.
- func3  input  3  op select.
- func7  input  7  must be 7'b0000001 for a legal op.
- rs1_val  input  XLEN  operand A.
- rs2_val  input  XLEN  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  op result.
- out_err  output  1  request was not a supported M op; result is 0.
- busy  output  1  state is not IDLE.

Behaviour:
- Clocking/reset: one clock. Reset is synchronous and active-low. While rst_n=0 at a rising edge:
  - state=IDLE; in_ready=1; out_valid=0; result=0; out_err=0; busy=0; counter and datapath registers are cleared.
- func3 op map:
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: high XLEN bits, signed x signed.
  - 010 MULHSU: high XLEN bits, signed rs1 x unsigned rs2.
  - 011 MULHU: high XLEN bits, unsigned x unsigned.
  - 100 DIV: signed quotient.
  - 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder.
  - 111 REMU: unsigned remainder.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1. A request is accepted when in_valid=1 at an edge; operands and op are latched.
  - Illegal request (instType is not INST_R_TYPE, func7 is not 0000001, or a div op with DIV_EN=0): go to DONE with result=0, out_err=1.
  - Div fast path, go to DONE with out_err=0:
    - rs2=0: DIV/DIVU result = all ones; REM/REMU result = rs1.
    - Signed overflow (DIV/REM, rs1 = most negative value, rs2 = all ones): DIV result = rs1; REM result = 0.
  - All other legal ops go to CALC with counter=XLEN.
- CALC:
  - Signed operands are converted to magnitudes; the sign of the final result is recorded.
  - Multiply: shift-add into a 2*XLEN accumulator, one bit per cycle.
  - Divide: restoring division, one quotient bit per cycle. The remainder register is XLEN+1 bits wide.
  - counter decrements each cycle. After XLEN cycles, go to DONE.
  - Final negation is applied on the DONE entry edge:
    - Product sign = sign(A) xor sign(B), using only the operands that are signed for the op.
    - Quotient sign = sign(A) xor sign(B).
    - Remainder sign = sign(A).
- Latency:
  - A request accepted at edge T gives out_valid=1 from edge T+XLEN+1 (CALC path) or from edge T+1 (fast or illegal path).
- DONE:
  - out_valid=1. result and out_err are held stable until out_ready=1 at an edge, then go to IDLE.
  - in_ready is 0 in DONE. The next request can be accepted one cycle after the handshake.
  - result is not cleared on leaving DONE; it holds its last value until the next DONE entry.
- Outputs: busy = (state != IDLE). in_ready = (state == IDLE).
- kill:
  - kill=1 at any edge (rst_n=1) forces IDLE, out_valid=0, out_err=0. The op is dropped with no result.
  - kill has priority over in_valid and out_ready in the same cycle.
  - rst_n=0 has priority over kill.
- Arithmetic: all arithmetic is two's complement modulo 2^XLEN. Operand changes after acceptance have no effect.

Test Plan:
- XLEN=32: MUL with 0x0000_0007 x 0xFFFF_FFFD -> after 33 cycles, result 0xFFFF_FFEB, out_err=0.
- MULH 0x8000_0000 x 0x8000_0000 -> 0x4000_0000. MULHU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFE. MULHSU 0xFFFF_FFFF x 0xFFFF_FFFF -> 0xFFFF_FFFF.
- DIV -7 / 2 -> 0xFFFF_FFFD; REM -7 / 2 -> 0xFFFF_FFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2. All after 33 cycles.
- Corner cases:
  - DIV x/0 with x=5 -> 0xFFFF_FFFF one cycle after accept.
  - REMU 5/0 -> 5.
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM of the same operands -> 0.
- Handshake:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid and result stable, in_ready=0.
  - Then pulse out_ready -> IDLE next cycle, back-to-back request accepted.
- Abort and errors:
  - kill at CALC cycle 10 -> IDLE next edge, no out_valid; next MUL 3x4 returns 12.
  - rst_n=0 mid-CALC -> all outputs at reset values.
  - func7=0000000 -> out_err=1, result=0 after 1 cycle.
